// File: rtl/irq_ctrl.sv
// AXI4-Lite interrupt controller: edge-latched status, per-source enables and a
// master enable, combined into one registered irq line.
module irq_ctrl #(
    parameter int C_S_AXI_ADDR_WIDTH = 5,
    parameter int C_NUM_INTR         = 4
) (
    input  logic                          s_axi_aclk,
    input  logic                          s_axi_aresetn,
    input  logic                          s_axi_awvalid,
    output logic                          s_axi_awready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0] s_axi_awaddr,
    input  logic                          s_axi_wvalid,
    output logic                          s_axi_wready,
    input  logic [31:0]                   s_axi_wdata,
    output logic                          s_axi_bvalid,
    input  logic                          s_axi_bready,
    output logic [1:0]                    s_axi_bresp,
    input  logic                          s_axi_arvalid,
    output logic                          s_axi_arready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0] s_axi_araddr,
    output logic [31:0]                   s_axi_rdata,
    output logic [1:0]                    s_axi_rresp,
    output logic                          s_axi_rvalid,
    input  logic                          s_axi_rready,
    input  logic [C_NUM_INTR-1:0]         intr_in,
    output logic                          irq
);

    localparam logic [2:0] IDX_ISR = 3'd0;
    localparam logic [2:0] IDX_IPR = 3'd1;
    localparam logic [2:0] IDX_IER = 3'd2;
    localparam logic [2:0] IDX_IAR = 3'd3;
    localparam logic [2:0] IDX_SIE = 3'd4;
    localparam logic [2:0] IDX_CIE = 3'd5;
    localparam logic [2:0] IDX_MER = 3'd6;

    logic [C_NUM_INTR-1:0] intr_q, isr_q, isr_d, ier_q, ier_d;
    logic [C_NUM_INTR-1:0] edge_det, iar_clr, wr_bits;
    logic                  mer_q, mer_d, irq_q, irq_d;
    logic                  awready_q, awready_d, bvalid_q, bvalid_d;
    logic                  arready_q, arready_d, rvalid_q, rvalid_d;
    logic [31:0]           rdata_q, rdata_d, rd_word;
    logic                  wr_en, rd_en;
    logic [2:0]            wr_idx, rd_idx;
    logic                  unused_bits;

    assign wr_idx      = s_axi_awaddr[4:2];
    assign rd_idx      = s_axi_araddr[4:2];
    assign wr_bits     = s_axi_wdata[C_NUM_INTR-1:0];
    assign unused_bits = ^{s_axi_awaddr, s_axi_araddr, s_axi_wdata};

    always_comb begin
        wr_en     = awready_q & s_axi_awvalid & s_axi_wvalid;
        rd_en     = arready_q & s_axi_arvalid;
        edge_det  = intr_in & ~intr_q;
        iar_clr   = (wr_en && wr_idx == IDX_IAR) ? wr_bits : '0;
        // A new edge beats a simultaneous acknowledge of the same bit.
        isr_d     = (isr_q & ~iar_clr) | edge_det;
        ier_d     = ier_q;
        mer_d     = mer_q;
        if (wr_en) begin
            case (wr_idx)
                IDX_IER: ier_d = wr_bits;
                IDX_SIE: ier_d = ier_q | wr_bits;
                IDX_CIE: ier_d = ier_q & ~wr_bits;
                IDX_MER: mer_d = s_axi_wdata[0];
                default: ;
            endcase
        end
        irq_d     = mer_q & (|(isr_q & ier_q));
        awready_d = s_axi_awvalid & s_axi_wvalid & ~bvalid_q & ~awready_q;
        bvalid_d  = wr_en | (bvalid_q & ~s_axi_bready);
        arready_d = s_axi_arvalid & ~rvalid_q & ~arready_q;
        rvalid_d  = rd_en | (rvalid_q & ~s_axi_rready);
    end

    // Read data is taken from pre-write register contents.
    always_comb begin
        rd_word = '0;
        case (rd_idx)
            IDX_ISR: rd_word[C_NUM_INTR-1:0] = isr_q;
            IDX_IPR: rd_word[C_NUM_INTR-1:0] = isr_q & ier_q;
            IDX_IER: rd_word[C_NUM_INTR-1:0] = ier_q;
            IDX_MER: rd_word[0]              = mer_q;
            default: ;
        endcase
        rdata_d = rd_en ? rd_word : rdata_q;
    end

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            intr_q    <= '0;
            isr_q     <= '0;
            ier_q     <= '0;
            mer_q     <= 1'b0;
            irq_q     <= 1'b0;
            awready_q <= 1'b0;
            bvalid_q  <= 1'b0;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
        end else begin
            intr_q    <= intr_in;
            isr_q     <= isr_d;
            ier_q     <= ier_d;
            mer_q     <= mer_d;
            irq_q     <= irq_d;
            awready_q <= awready_d;
            bvalid_q  <= bvalid_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
        end
    end

    assign s_axi_awready = awready_q;
    assign s_axi_wready  = awready_q;
    assign s_axi_bvalid  = bvalid_q;
    assign s_axi_bresp   = 2'b00;
    assign s_axi_arready = arready_q;
    assign s_axi_rvalid  = rvalid_q;
    assign s_axi_rdata   = rdata_q;
    assign s_axi_rresp   = 2'b00;
    assign irq           = irq_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// Scoreboard bench for irq_ctrl: reads push expected data, a negedge monitor
// pops and compares on each read handshake; irq timing is checked inline.
module tb_irq_ctrl;

    localparam int NI = 4;
    localparam logic [4:0] A_ISR = 5'h00;
    localparam logic [4:0] A_IPR = 5'h04;
    localparam logic [4:0] A_IER = 5'h08;
    localparam logic [4:0] A_IAR = 5'h0C;
    localparam logic [4:0] A_SIE = 5'h10;
    localparam logic [4:0] A_CIE = 5'h14;
    localparam logic [4:0] A_MER = 5'h18;
    localparam logic [4:0] A_RSV = 5'h1C;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          awvalid = 1'b0, wvalid = 1'b0, bready = 1'b1;
    logic          arvalid = 1'b0, rready = 1'b1;
    logic [4:0]    awaddr = '0, araddr = '0;
    logic [31:0]   wdata = '0;
    logic [NI-1:0] intr_in = '0;
    logic          awready, wready, bvalid, arready, rvalid, irq;
    logic [1:0]    bresp, rresp;
    logic [31:0]   rdata;

    int            checks = 0;
    int            errors = 0;
    int            reads_issued = 0, reads_seen = 0;
    int            writes_issued = 0, bresp_seen = 0;
    logic [31:0]   exp_q[$];
    string         name_q[$];
    logic [31:0]   mon_exp;
    string         mon_name;

    irq_ctrl #(.C_S_AXI_ADDR_WIDTH(5), .C_NUM_INTR(NI)) dut (
        .s_axi_aclk(clk), .s_axi_aresetn(rst_n),
        .s_axi_awvalid(awvalid), .s_axi_awready(awready), .s_axi_awaddr(awaddr),
        .s_axi_wvalid(wvalid), .s_axi_wready(wready), .s_axi_wdata(wdata),
        .s_axi_bvalid(bvalid), .s_axi_bready(bready), .s_axi_bresp(bresp),
        .s_axi_arvalid(arvalid), .s_axi_arready(arready), .s_axi_araddr(araddr),
        .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid),
        .s_axi_rready(rready), .intr_in(intr_in), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic timeoutFail(input string name);
        checks++;
        errors++;
        $display("[TB] FAIL %s: timed out waiting for DUT", name);
    endtask

    // Monitor: compare every read and write response at its handshake.
    always @(negedge clk) begin
        if (rst_n && rvalid && rready) begin
            reads_seen++;
            if (exp_q.size() == 0) begin
                timeoutFail("unexpected read response");
            end else begin
                mon_exp  = exp_q.pop_front();
                mon_name = name_q.pop_front();
                checkOutput(mon_name, rdata, mon_exp);
                checkOutput("rresp", 32'(rresp), 32'h0);
            end
        end
        if (rst_n && bvalid && bready) begin
            bresp_seen++;
            checkOutput("bresp", 32'(bresp), 32'h0);
        end
    end

    task automatic applyStimulus(input logic [NI-1:0] value);
        @(posedge clk); #1;
        intr_in = value;
    endtask

    task automatic writeIssue(input logic [4:0] addr, input logic [31:0] data,
                              input logic [NI-1:0] edge_at_accept);
        bit ok = 0;
        awaddr = addr; wdata = data; awvalid = 1'b1; wvalid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (awready) begin ok = 1; break; end
        end
        if (!ok) timeoutFail("write accept");
        intr_in = intr_in | edge_at_accept;
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        writes_issued++;
    endtask

    task automatic waitBresp();
        int n = 0;
        while (bresp_seen != writes_issued && n < 100) begin
            @(posedge clk); #1; n++;
        end
        if (bresp_seen != writes_issued) timeoutFail("write response");
    endtask

    task automatic axiWrite(input logic [4:0] addr, input logic [31:0] data);
        writeIssue(addr, data, '0);
        waitBresp();
    endtask

    task automatic axiRead(input logic [4:0] addr, input logic [31:0] expected,
                           input string name);
        bit ok = 0;
        int n = 0;
        exp_q.push_back(expected);
        name_q.push_back(name);
        araddr = addr; arvalid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (arready) begin ok = 1; break; end
        end
        if (!ok) timeoutFail("read accept");
        @(posedge clk); #1;
        arvalid = 1'b0;
        reads_issued++;
        while (reads_seen != reads_issued && n < 100) begin
            @(posedge clk); #1; n++;
        end
        if (reads_seen != reads_issued) timeoutFail("read response");
    endtask

    initial begin
        // Reset state
        #12;
        checkOutput("reset irq", 32'(irq), 32'h0);
        checkOutput("reset awready", 32'(awready), 32'h0);
        checkOutput("reset wready", 32'(wready), 32'h0);
        checkOutput("reset bvalid", 32'(bvalid), 32'h0);
        checkOutput("reset arready", 32'(arready), 32'h0);
        checkOutput("reset rvalid", 32'(rvalid), 32'h0);
        checkOutput("reset rdata", rdata, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) axiRead(5'(i * 4), 32'h0, "reset read offset");
        checkOutput("irq after reset reads", 32'(irq), 32'h0);

        // Single pulse on source 0, irq lags ISR by one cycle
        axiWrite(A_IER, 32'h1);
        axiWrite(A_MER, 32'h1);
        applyStimulus(4'b0001);
        applyStimulus(4'b0000);
        checkOutput("irq one cycle after ISR set", 32'(irq), 32'h0);
        @(posedge clk); #1;
        checkOutput("irq rises", 32'(irq), 32'h1);
        axiRead(A_ISR, 32'h1, "ISR after pulse0");
        axiRead(A_IPR, 32'h1, "IPR after pulse0");
        writeIssue(A_IAR, 32'h1, '0);
        checkOutput("irq held right after IAR", 32'(irq), 32'h1);
        @(posedge clk); #1;
        checkOutput("irq falls after IAR", 32'(irq), 32'h0);
        waitBresp();
        axiRead(A_ISR, 32'h0, "ISR after IAR0");

        // Held level on source 2 with enable off, then SIE/CIE
        axiWrite(A_IER, 32'h0);
        applyStimulus(4'b0100);
        repeat (20) @(posedge clk);
        #1;
        axiRead(A_ISR, 32'h4, "ISR held src2");
        axiRead(A_IPR, 32'h0, "IPR masked src2");
        checkOutput("irq masked src2", 32'(irq), 32'h0);
        axiWrite(A_SIE, 32'h4);
        axiRead(A_IER, 32'h4, "IER after SIE");
        axiRead(A_IPR, 32'h4, "IPR after SIE");
        checkOutput("irq after SIE", 32'(irq), 32'h1);
        axiWrite(A_CIE, 32'h4);
        axiRead(A_IER, 32'h0, "IER after CIE");
        checkOutput("irq after CIE", 32'(irq), 32'h0);
        axiWrite(A_IAR, 32'h4);
        axiRead(A_ISR, 32'h0, "ISR level held no re-edge");
        applyStimulus(4'b0000);

        // Unimplemented bits, write-only and reserved offsets
        axiWrite(A_IER, 32'hFFFF_FFFF);
        axiRead(A_IER, 32'hF, "IER upper bits ignored");
        axiWrite(A_CIE, 32'hFFFF_FFFF);
        axiRead(A_IER, 32'h0, "IER after CIE all");
        axiWrite(A_MER, 32'hFFFF_FFFF);
        axiRead(A_MER, 32'h1, "MER only bit0");
        axiWrite(A_RSV, 32'hFFFF_FFFF);
        axiRead(A_RSV, 32'h0, "reserved reads 0");
        axiRead(A_IAR, 32'h0, "IAR reads 0");
        axiRead(A_SIE, 32'h0, "SIE reads 0");
        axiRead(A_CIE, 32'h0, "CIE reads 0");

        // Edge in the same cycle as the IAR clear of that bit
        applyStimulus(4'b0010);
        applyStimulus(4'b0000);
        axiRead(A_ISR, 32'h2, "ISR after pulse1");
        writeIssue(A_IAR, 32'h2, 4'b0010);
        intr_in = '0;
        waitBresp();
        axiRead(A_ISR, 32'h2, "ISR set wins over IAR");
        axiWrite(A_IAR, 32'h2);
        axiRead(A_ISR, 32'h0, "ISR after plain IAR1");

        // AW before W, and bready held low
        bready = 1'b0;
        awaddr = A_IER; wdata = 32'h5; awvalid = 1'b1; wvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("awready without W", 32'(awready), 32'h0);
        end
        @(posedge clk); #1;
        wvalid = 1'b1;
        writeIssue(A_IER, 32'h5, '0);
        awaddr = A_IER; wdata = 32'h9; awvalid = 1'b1; wvalid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("bvalid held", 32'(bvalid), 32'h1);
            checkOutput("no second accept", 32'(awready), 32'h0);
        end
        @(posedge clk); #1;
        bready = 1'b1;
        @(posedge clk); #1;
        checkOutput("bvalid drops after handshake", 32'(bvalid), 32'h0);
        writeIssue(A_IER, 32'h9, '0);
        waitBresp();
        axiRead(A_IER, 32'h9, "IER second write");

        // Asynchronous reset while a read response is pending
        axiWrite(A_IER, 32'hF);
        applyStimulus(4'b1111);
        applyStimulus(4'b0000);
        axiRead(A_ISR, 32'hF, "ISR all sources");
        checkOutput("irq all sources", 32'(irq), 32'h1);
        rready = 1'b0;
        araddr = A_ISR; arvalid = 1'b1;
        begin
            bit ok = 0;
            for (int i = 0; i < 100; i++) begin
                @(posedge clk); #1;
                if (rvalid) begin ok = 1; break; end
                if (arready) arvalid = 1'b1;
            end
            arvalid = 1'b0;
            if (!ok) timeoutFail("pending rvalid");
        end
        checkOutput("pending rdata", rdata, 32'hF);
        #2;
        rst_n = 1'b0;
        intr_in = 4'b1000;
        #1;
        checkOutput("async reset rvalid", 32'(rvalid), 32'h0);
        checkOutput("async reset irq", 32'(irq), 32'h0);
        checkOutput("async reset rdata", rdata, 32'h0);
        @(posedge clk); #1;
        rready = 1'b1;
        rst_n = 1'b1;
        axiRead(A_ISR, 32'h8, "ISR edge at reset release");
        axiRead(A_IER, 32'h0, "IER after reset");
        axiRead(A_MER, 32'h0, "MER after reset");
        checkOutput("irq after reset", 32'(irq), 32'h0);
        applyStimulus(4'b0000);

        checkOutput("scoreboard drained", 32'(exp_q.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/irq_ctrl.md
Name: irq_ctrl

Overview:
- AXI4-Lite interrupt controller that sits directly downstream of the programmable interval timer and the other interrupt sources.
- Collects up to C_NUM_INTR interrupt lines (the PIT irq on bit 0), latches rising edges into a status register, and masks them per source and globally.
- Drives one combined irq to the processor.
- Software reads, acknowledges and enables sources over an AXI4-Lite slave port.

Parameters:
- C_S_AXI_ADDR_WIDTH, 5, byte-address width of the register space (8 words).
- C_NUM_INTR, 4, number of interrupt inputs (1..32). Register bits at and above C_NUM_INTR read 0 and ignore writes.

Ports:
- s_axi_aclk  in  1  clock.
- s_axi_aresetn  in  1  asynchronous active-low reset.
- s_axi_awvalid  in  1  write address valid.
- s_axi_awready  out  1  write address ready.
- s_axi_awaddr  in  C_S_AXI_ADDR_WIDTH  write byte address.
- s_axi_wvalid  in  1  write data valid.
- s_axi_wready  out  1  write data ready.
- s_axi_wdata  in  32  write data.
- s_axi_bvalid  out  1  write response valid.
- s_axi_bready  in  1  write response ready.
- s_axi_bresp  out  2  write response, always 2'b00.
- s_axi_arvalid  in  1  read address valid.
- s_axi_arready  out  1  read address ready.
- s_axi_araddr  in  C_S_AXI_ADDR_WIDTH  read byte address.
- s_axi_rdata  out  32  read data.
- s_axi_rresp  out  2  read response, always 2'b00.
- s_axi_rvalid  out  1  read data valid.
- s_axi_rready  in  1  read data ready.
- intr_in  in  C_NUM_INTR  interrupt sources, synchronous to s_axi_aclk, active high.
- irq  out  1  combined interrupt to the CPU, active high.

Behaviour:
- Reset (s_axi_aresetn=0, asynchronous): ISR, IER, MER and the edge-detect register intr_q clear to 0.
  - awready, wready, bvalid, arready, rvalid and irq = 0; rdata = 0.
  - Any in-flight transaction is dropped.
- Edge detect: edge = intr_in & ~intr_q, with intr_q <= intr_in every cycle.
  - An input already high at reset release counts as one rising edge on the first clock.
  - A level held high produces no further edges.
- Register map (word aligned; address bits [1:0] ignored):
  - 0x00 ISR: RO status. Bit set on edge.
  - 0x04 IPR: RO, equals ISR & IER.
  - 0x08 IER: RW enables.
  - 0x0C IAR: WO. Writing 1 clears the ISR bit; reads 0.
  - 0x10 SIE: WO. Writing 1 sets the IER bit; reads 0.
  - 0x14 CIE: WO. Writing 1 clears the IER bit; reads 0.
  - 0x18 MER: bit0 RW master enable, other bits read 0.
  - 0x1C: reserved. Reads 0, writes ignored, OKAY response.
- ISR update per cycle: ISR <= (ISR & ~iar_clear) | edge.
  - Set wins: an edge arriving in the same cycle as an IAR clear of the same bit leaves the bit at 1.
- irq is registered: irq <= MER[0] & |(ISR & IER). It follows any ISR, IER or MER change by exactly 1 cycle.
- Write channel:
  - awready and wready pulse high together for one cycle when awvalid & wvalid & ~bvalid.
  - The register write takes effect on that edge.
  - bvalid rises the next cycle and holds until bready; bvalid drops the cycle after the bready handshake.
  - AW without W, or W without AW, waits without being accepted.
  - Only one write is outstanding at a time.
- Read channel:
  - arready pulses for one cycle when arvalid & ~rvalid & ~arready.
  - rdata is captured on that edge from the current register values; rvalid rises the next cycle.
  - rdata and rvalid are held stable until rready.
  - Only one read is outstanding at a time.
- A read and a write may complete in the same cycle. A read of ISR in the same cycle as an IAR write returns the pre-write value.
- bresp and rresp are constant 2'b00.

Test Plan:
- Reset, then read all 8 offsets -> every rdata = 0x0, irq = 0, bresp and rresp = 00.
- Write IER=0x1, MER=0x1, then pulse intr_in[0] for 1 cycle -> ISR reads 0x1, IPR reads 0x1, irq rises 1 cycle after the ISR bit sets. Write IAR=0x1 -> ISR=0x0, irq falls 1 cycle later.
- Hold intr_in[2] high for 20 cycles with IER=0x0 -> ISR=0x4, IPR=0x0, irq=0. Write SIE=0x4 -> IER=0x4 and irq=1. Write CIE=0x4 -> irq=0.
- Raise an intr_in[1] edge in the exact cycle an IAR=0x2 write is accepted -> ISR[1] stays 1.
- Present AW 3 cycles before W, and hold bready low for 5 cycles -> awready and wready rise together only once both are valid; bvalid stays high until bready; no second write is accepted meanwhile.
- Assert s_axi_aresetn low for 1 cycle while rvalid is high with ISR=0xF -> rvalid, irq and ISR all 0 immediately, without waiting for a clock edge.
